// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider: multi-cycle unsigned restoring divider.
// One trial subtraction per clock (R + ~D + 1), WIDTH steps per operation,
// behind a start/done handshake. Results are registered and held between
// operations; a zero divisor short-circuits straight to the DONE state.
//
// Handshake: start is sampled on any rising edge where busy = 0 (IDLE or
// DONE state); that edge captures the operands. done is a one-cycle pulse
// and the result outputs are valid from that cycle until the next accepted
// start completes. start while busy = 1 is dropped, not queued.
module seq_restoring_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH:0]   r_q;          // partial remainder, one extra bit for the borrow
    logic [WIDTH-1:0] q_q;          // dividend shifting out / quotient shifting in
    logic [WIDTH-1:0] d_q;          // captured divisor
    logic [CW-1:0]    cnt_q;        // steps completed in this operation
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;
    logic             dbz_q;

    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   r_d;
    logic [WIDTH-1:0] q_d;

    // One restoring step: shift {R,Q} left, trial-subtract D as R + ~D + 1,
    // keep the difference only when it did not borrow.
    always_comb begin
        r_shift = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
        trial   = r_shift + ~{1'b0, d_q} + {{WIDTH{1'b0}}, 1'b1};
        r_d     = r_shift;
        q_d     = {q_q[WIDTH-2:0], 1'b0};
        if (!trial[WIDTH]) begin
            r_d = trial;
            q_d = {q_q[WIDTH-2:0], 1'b1};
        end
    end

    // Control FSM, datapath registers and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            r_q         <= '0;
            q_q         <= '0;
            d_q         <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    state_q <= S_IDLE;
                    if (start) begin
                        if (divisor == '0) begin
                            // Nothing to iterate: publish the saturated result now.
                            quotient_q  <= '1;
                            remainder_q <= dividend;
                            dbz_q       <= 1'b1;
                            state_q     <= S_DONE;
                        end else begin
                            r_q     <= '0;
                            q_q     <= dividend;
                            d_q     <= divisor;
                            cnt_q   <= '0;
                            state_q <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    r_q   <= r_d;
                    q_q   <= q_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST_STEP) begin
                        quotient_q  <= q_d;
                        remainder_q <= r_d[WIDTH-1:0];
                        dbz_q       <= 1'b0;
                        state_q     <= S_DONE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy        = (state_q == S_RUN);
    assign done        = (state_q == S_DONE);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Bench for seq_restoring_divider: an 8-bit and a 16-bit instance, each with
// a driver that pushes reference results into a queue and a monitor that
// pops and compares whenever done is seen. Busy timing, result latency and
// result hold between operations are all checked against the driver's model.
module tb_seq_restoring_divider;

    typedef struct {
        logic [15:0] q;
        logic [15:0] r;
        logic        dbz;
        int          cyc;   // negedge-sample index where done must be high
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    // 8-bit instance
    logic       start8 = 1'b0;
    logic [7:0] dvd8 = '0, dvs8 = '0;
    logic       busy8, done8, dbz8;
    logic [7:0] quo8, rem8;

    // 16-bit instance
    logic        start16 = 1'b0;
    logic [15:0] dvd16 = '0, dvs16 = '0;
    logic        busy16, done16, dbz16;
    logic [15:0] quo16, rem16;

    seq_restoring_divider #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .dividend(dvd8), .divisor(dvs8),
        .busy(busy8), .done(done8), .quotient(quo8), .remainder(rem8),
        .div_by_zero(dbz8)
    );

    seq_restoring_divider #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .dividend(dvd16), .divisor(dvs16),
        .busy(busy16), .done(done16), .quotient(quo16), .remainder(rem16),
        .div_by_zero(dbz16)
    );

    // ---------------- clock / cycle count ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- model state ----------------
    exp_t exp8_q[$];
    exp_t exp16_q[$];
    exp_t last8, last16;      // results the outputs must hold
    int   free8 = 0, free16 = 0;   // first sample index a new start is accepted
    int   bs8 = 0, be8 = -1, bs16 = 0, be16 = -1;  // expected busy window

    function automatic exp_t ref_div(input int a, input int b, input int w);
        exp_t e;
        int   mask;
        mask = (1 << w) - 1;
        if (b == 0) begin
            e.q = 16'(mask);
            e.r = 16'(a);
            e.dbz = 1'b1;
        end else begin
            e.q = 16'(a / b);
            e.r = 16'(a % b);
            e.dbz = 1'b0;
        end
        e.cyc = 0;
        return e;
    endfunction

    function automatic exp_t zero_exp();
        exp_t e;
        e.q = '0; e.r = '0; e.dbz = 1'b0; e.cyc = 0;
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic op8(input int a, input int b, input int idle);
        exp_t e;
        repeat (idle) @(negedge clk);
        while (cyc < free8) @(negedge clk);
        start8 = 1'b1;
        dvd8 = 8'(a);
        dvs8 = 8'(b);
        e = ref_div(a, b, 8);
        e.cyc = cyc + 1 + ((b == 0) ? 0 : 8);
        if (b != 0) begin
            bs8 = cyc + 1;
            be8 = cyc + 8;
        end
        free8 = e.cyc;
        exp8_q.push_back(e);
        @(negedge clk);
        start8 = 1'b0;
        dvd8 = 8'($urandom);
        dvs8 = 8'($urandom);
    endtask

    task automatic op16(input int a, input int b, input int idle);
        exp_t e;
        repeat (idle) @(negedge clk);
        while (cyc < free16) @(negedge clk);
        start16 = 1'b1;
        dvd16 = 16'(a);
        dvs16 = 16'(b);
        e = ref_div(a, b, 16);
        e.cyc = cyc + 1 + ((b == 0) ? 0 : 16);
        if (b != 0) begin
            bs16 = cyc + 1;
            be16 = cyc + 16;
        end
        free16 = e.cyc;
        exp16_q.push_back(e);
        @(negedge clk);
        start16 = 1'b0;
        dvd16 = 16'($urandom);
        dvs16 = 16'($urandom);
    endtask

    // ---------------- monitors / scoreboard ----------------
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            chk("w8 busy", 64'(busy8), 64'(cyc >= bs8 && cyc <= be8));
            if (done8) begin
                if (exp8_q.size() == 0) begin
                    chk("w8 unexpected done", 64'(done8), 64'(0));
                end else begin
                    e = exp8_q.pop_front();
                    chk("w8 quotient", 64'(quo8), 64'(e.q[7:0]));
                    chk("w8 remainder", 64'(rem8), 64'(e.r[7:0]));
                    chk("w8 div_by_zero", 64'(dbz8), 64'(e.dbz));
                    chk("w8 done cycle", 64'(cyc), 64'(e.cyc));
                    last8 = e;
                end
            end else begin
                chk("w8 hold", 64'({dbz8, rem8, quo8}),
                    64'({last8.dbz, last8.r[7:0], last8.q[7:0]}));
                if (exp8_q.size() != 0 && cyc > exp8_q[0].cyc) begin
                    chk("w8 missing done", 64'(done8), 64'(1));
                    void'(exp8_q.pop_front());
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            chk("w16 busy", 64'(busy16), 64'(cyc >= bs16 && cyc <= be16));
            if (done16) begin
                if (exp16_q.size() == 0) begin
                    chk("w16 unexpected done", 64'(done16), 64'(0));
                end else begin
                    e = exp16_q.pop_front();
                    chk("w16 quotient", 64'(quo16), 64'(e.q));
                    chk("w16 remainder", 64'(rem16), 64'(e.r));
                    chk("w16 div_by_zero", 64'(dbz16), 64'(e.dbz));
                    chk("w16 done cycle", 64'(cyc), 64'(e.cyc));
                    last16 = e;
                end
            end else begin
                chk("w16 hold", 64'({dbz16, rem16, quo16}),
                    64'({last16.dbz, last16.r, last16.q}));
                if (exp16_q.size() != 0 && cyc > exp16_q[0].cyc) begin
                    chk("w16 missing done", 64'(done16), 64'(1));
                    void'(exp16_q.pop_front());
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        errors++;
        checks++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // ---------------- main sequence ----------------
    initial begin
        int a, b;
        last8 = zero_exp();
        last16 = zero_exp();

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset busy8", 64'(busy8), 64'(0));
        chk("reset done8", 64'(done8), 64'(0));
        chk("reset outputs8", 64'({dbz8, rem8, quo8}), 64'(0));
        chk("reset outputs16", 64'({busy16, done16, dbz16, rem16, quo16}), 64'(0));
        rst = 1'b0;
        free8 = cyc;
        free16 = cyc;
        @(negedge clk);

        // Basic operation and boundaries
        op8(200, 7, 0);
        op8(255, 1, 1);
        op8(3, 10, 0);
        op8(0, 5, 2);
        op8(255, 255, 0);
        // Divide by zero, then a normal op clears the flag
        op8(5, 0, 1);
        op8(9, 3, 0);

        // Start while busy is ignored; captured operands are not disturbed
        op8(100, 9, 1);
        repeat (2) @(negedge clk);
        start8 = 1'b1;
        dvd8 = 8'd1;
        dvs8 = 8'd1;
        @(negedge clk);
        start8 = 1'b0;
        // Accepted in the done cycle of 100/9
        op8(50, 6, 0);
        // Idle for a while: results must hold
        while (cyc < free8 + 6) @(negedge clk);

        // Async reset in the middle of a run
        op8(200, 7, 0);
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrun reset busy8", 64'(busy8), 64'(0));
        chk("midrun reset done8", 64'(done8), 64'(0));
        chk("midrun reset outputs8", 64'({dbz8, rem8, quo8}), 64'(0));
        exp8_q.delete();
        last8 = zero_exp();
        bs8 = 0;
        be8 = -1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        free8 = cyc;
        op8(200, 7, 2);

        // Randomized, 8-bit
        for (int i = 0; i < 1000; i++) begin
            a = $urandom_range(0, 255);
            b = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(0, 255);
            op8(a, b, $urandom_range(0, 2));
        end

        // Randomized, 16-bit
        op16(65535, 1, 0);
        op16(12345, 0, 0);
        for (int i = 0; i < 1000; i++) begin
            a = $urandom_range(0, 65535);
            b = ($urandom_range(0, 9) == 0) ? 0 :
                (($urandom_range(0, 3) == 0) ? $urandom_range(1, 15) : $urandom_range(0, 65535));
            op16(a, b, $urandom_range(0, 2));
        end

        // Drain and final report
        while (cyc <= free8 + 3 || cyc <= free16 + 3) @(negedge clk);
        chk("w8 queue drained", 64'(exp8_q.size()), 64'(0));
        chk("w16 queue drained", 64'(exp16_q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
